// File: rtl/sparse_column_fetch_scheduler.sv
// Round-robin scheduler sharing one CSC column reader between NUM_REQ requesters.
// Optional watchdog enabled by defining SBM_SCHED_TIMEOUT_EN.
module sparse_column_fetch_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_col,
  output logic [NUM_REQ-1:0]            req_accept,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_col,
  input  logic                          mem_ack,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_value,
  input  logic [ADDR_WIDTH-1:0]         mem_rsp_row,
  input  logic                          mem_rsp_last,
  input  logic                          mem_rsp_empty,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_value,
  output logic [ADDR_WIDTH-1:0]         out_row,
  output logic                          out_last,
  output logic                          out_empty,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          fetch_count,
  output logic [CNT_WIDTH-1:0]          entry_count,
  output logic                          err_timeout
);

  // state   | meaning
  // IDLE    | arbitrate among pending requests
  // ISSUE   | hold mem_req/mem_col until mem_ack
  // STREAM  | forward response beats tagged with owner id
  // RELEASE | advance rr pointer, count the completed fetch
  typedef enum logic [1:0] {IDLE, ISSUE, STREAM, RELEASE} state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [NUM_REQ-1:0]    accept_q, accept_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_value_q, out_value_d;
  logic [ADDR_WIDTH-1:0] out_row_q, out_row_d;
  logic                  out_last_q, out_last_d;
  logic                  out_empty_q, out_empty_d;
  logic [CNT_WIDTH-1:0]  fetch_q, fetch_d;
  logic [CNT_WIDTH-1:0]  entry_q, entry_d;

  logic [ADDR_WIDTH-1:0] col_arr [NUM_REQ];
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   cand_id;
  logic                  fetch_ok;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      col_arr[i] = req_col[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Cyclic search starting just after the last served requester.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand_id     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_id = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_id    = cand_id;
      end
    end
  end

`ifdef SBM_SCHED_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_WIDTH-1:0] wd_q, wd_d;
  logic                err_q, err_d;
  logic                to_q, to_d;

  assign fetch_ok    = !to_q;
  assign err_timeout = err_q;
`else
  assign fetch_ok    = 1'b1;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    col_d       = col_q;
    accept_d    = '0;
    out_valid_d = 1'b0;
    out_value_d = out_value_q;
    out_row_d   = out_row_q;
    out_last_d  = 1'b0;
    out_empty_d = 1'b0;
    fetch_d     = fetch_q;
    entry_d     = entry_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          id_d               = grant_id;
          col_d              = col_arr[grant_id];
          accept_d[grant_id] = 1'b1;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) state_d = STREAM;
      end
      STREAM: begin
        // A valid beat wins over a simultaneous empty indication.
        if (mem_rsp_valid) begin
          out_valid_d = 1'b1;
          out_value_d = mem_rsp_value;
          out_row_d   = mem_rsp_row;
          out_last_d  = mem_rsp_last;
          if (entry_q != '1) entry_d = entry_q + CNT_WIDTH'(1);
          if (mem_rsp_last) state_d = RELEASE;
        end else if (mem_rsp_empty) begin
          out_empty_d = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        rr_ptr_d = id_q;
        if (fetch_ok && fetch_q != '1) fetch_d = fetch_q + CNT_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef SBM_SCHED_TIMEOUT_EN
    wd_d  = '0;
    err_d = err_q;
    to_d  = to_q;
    if (state_q == ISSUE || state_q == STREAM) begin
      if (mem_ack || (state_q == STREAM && (mem_rsp_valid || mem_rsp_empty))) begin
        wd_d = '0;
      end else if (wd_q == WD_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        err_d       = 1'b1;
        to_d        = 1'b1;
        out_valid_d = 1'b0;
        out_empty_d = 1'b0;
        out_last_d  = 1'b1;
        state_d     = RELEASE;
      end else begin
        wd_d = wd_q + WD_WIDTH'(1);
      end
    end
    if (state_q == RELEASE) to_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
      id_q        <= '0;
      col_q       <= '0;
      accept_q    <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      out_empty_q <= 1'b0;
      fetch_q     <= '0;
      entry_q     <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      col_q       <= col_d;
      accept_q    <= accept_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      out_empty_q <= out_empty_d;
      fetch_q     <= fetch_d;
      entry_q     <= entry_d;
    end
  end

`ifdef SBM_SCHED_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
      to_q  <= to_d;
    end
  end
`endif

  assign req_accept  = accept_q;
  assign mem_req     = (state_q == ISSUE);
  assign mem_col     = col_q;
  assign out_valid   = out_valid_q;
  assign out_value   = out_value_q;
  assign out_row     = out_row_q;
  assign out_last    = out_last_q;
  assign out_empty   = out_empty_q;
  assign out_id      = id_q;
  assign busy        = (state_q != IDLE);
  assign fetch_count = fetch_q;
  assign entry_count = entry_q;

endmodule

// File: doc/sparse_column_fetch_scheduler.md
# sparse_column_fetch_scheduler

Round-robin scheduler that shares one sparse boundary-matrix column reader (CSC store) between several persistence-reduction requesters. It accepts column-fetch requests, issues one column fetch at a time to the matrix port, and routes the streamed (value, row) entries back tagged with the requester ID. It also keeps fetch and entry statistics. It sits between the reduction engines and the sparse matrix processor in the persistence engine.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ID_WIDTH`, 2: requester ID width; must equal `$clog2(NUM_REQ)`.
- `DATA_WIDTH`, 16: entry value width.
- `ADDR_WIDTH`, 12: column/row index width.
- `CNT_WIDTH`, 16: statistics counter width.
- `TIMEOUT_CYCLES`, 256: watchdog limit; used only with the macro.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester fetch request; held until accepted.
- `req_col`  in  NUM_REQ*ADDR_WIDTH  column index; requester i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_accept`  out  NUM_REQ  one-hot, 1-cycle pulse: request latched.
- `mem_req`  out  1  column fetch request to matrix port.
- `mem_col`  out  ADDR_WIDTH  column to fetch.
- `mem_ack`  in  1  matrix port accepted the fetch.
- `mem_rsp_valid`  in  1  entry valid.
- `mem_rsp_value`  in  DATA_WIDTH  entry value.
- `mem_rsp_row`  in  ADDR_WIDTH  entry row index.
- `mem_rsp_last`  in  1  final entry of the column (qualified by `mem_rsp_valid`).
- `mem_rsp_empty`  in  1  column has no entries; 1-cycle pulse, no `mem_rsp_valid`.
- `out_valid`, `out_value`, `out_row`, `out_last`, `out_empty`  out  1/DATA_WIDTH/ADDR_WIDTH/1/1  registered copy of the response stream.
- `out_id`  out  ID_WIDTH  owner of the current output beat.
- `busy`  out  1  high in any state other than IDLE.
- `fetch_count`, `entry_count`  out  CNT_WIDTH  completed fetches and forwarded entries; both saturate.
- `err_timeout`  out  1  sticky watchdog flag; tied 0 without the macro.

## Operation
- FSM states: IDLE, ISSUE, STREAM, RELEASE.
- IDLE, any `req_valid` high:
  - Winner is the first requester after `rr_ptr`, searching cyclically.
  - Latch winner ID and its `req_col`.
  - Pulse `req_accept[winner]`.
  - Go to ISSUE.
- ISSUE: `mem_req`=1 and `mem_col` is the latched column, both held until `mem_ack`; then go to STREAM.
- STREAM: each `mem_rsp_valid` is forwarded to `out_*` with `out_id`; `entry_count`++.
  - `mem_rsp_last` or `mem_rsp_empty` ends the fetch: go to RELEASE.
  - An empty column forwards one beat: `out_valid`=0, `out_empty`=1.
- RELEASE: `rr_ptr` set to the served ID; `fetch_count`++; go to IDLE.
- Requests are not arbitrated outside IDLE. A requester may hold `req_valid` through the accept cycle.
- Response inputs outside STREAM are ignored.
- If `mem_rsp_valid` and `mem_rsp_empty` are high together, `empty` is ignored and the beat is a normal entry.
- Counters saturate at all-ones and never wrap.
- Reset, including mid-fetch:
  - State is IDLE and `rr_ptr`=NUM_REQ-1, so requester 0 wins first.
  - All outputs are 0, counters are 0, `err_timeout`=0.
  - An in-flight column is abandoned. The matrix port is reset by the same `rst`.

## Timing
- `req_valid` sampled at edge N gives `req_accept` and `mem_req` high after edge N, i.e. during cycle N+1.
- `mem_ack` sampled at edge M: `mem_req` drops after M and STREAM starts.
- Response-to-output latency is 1 cycle. `out_*` are registered, so `out_valid` after edge K mirrors `mem_rsp_valid` at K.
- RELEASE and IDLE take 1 cycle each. Back-to-back fetches therefore leave a minimum of 2 cycles between the last beat and the next `mem_req`.
- `out_last` and `out_empty` are 1-cycle pulses. `out_id` is stable for the whole fetch.

## Configuration
- `SBM_SCHED_TIMEOUT_EN` defined: watchdog counter runs in ISSUE and STREAM and clears on every `mem_ack` or response beat.
  - When it reaches `TIMEOUT_CYCLES`: set `err_timeout` (sticky until `rst`) and emit `out_last`=1, `out_valid`=0 with the current `out_id`.
  - Then go to RELEASE; `fetch_count` is not incremented.
- Not defined: no watchdog logic; a hung matrix port stalls the FSM indefinitely; `err_timeout`=0.

## Test plan
- Reset then `req_valid`=4'b0001, col 5; 3 entries then last:
  - `req_accept`=0001; `mem_col`=5.
  - 3 `out_valid` beats with `out_id`=0; `out_last` on the 3rd.
  - `fetch_count`=1, `entry_count`=3.
- `req_valid`=4'b1111 held continuously: grant order is 0,1,2,3,0; each `req_accept` is one-hot.
- Column with `mem_rsp_empty`: one `out_empty` pulse, `out_valid` never high, `fetch_count`+1, `entry_count` unchanged.
- `mem_ack` delayed 10 cycles: `mem_req` and `mem_col` stay stable for 10 cycles; no output beats in that time.
- `rst` asserted mid-STREAM after 2 of 5 entries: next cycle `busy`=0, counters 0, `out_valid`=0; a new request to ID 2 is served normally.
- With `SBM_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, no response after `mem_ack`:
  - After 16 cycles, `err_timeout`=1 and one `out_last` beat.
  - FSM returns to IDLE; `fetch_count` unchanged.
